// File: rtl/asym_ram_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// asym_ram_arbiter_pkg: shared types and default widths for the arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
package asym_ram_arbiter_pkg;

  localparam int c_DEF_WIDTHA     = 16;
  localparam int c_DEF_ADDRWIDTHA = 8;
  localparam int c_DEF_WIDTHB     = 4;
  localparam int c_DEF_ADDRWIDTHB = 10;
  localparam int c_DEF_LANES      = c_DEF_WIDTHA / c_DEF_WIDTHB;
  localparam int c_DEF_LANE_W     = $clog2(c_DEF_LANES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

  // Lane-select width; kept at least 1 so a degenerate 1:1 ratio still elaborates.
  function automatic int lane_w(input int wa, input int wb);
    return ((wa / wb) > 1) ? $clog2(wa / wb) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/asym_ram_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// asym_ram_arbiter_if: requester handshakes plus the RAM macro port.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface asym_ram_arbiter_if #(
  parameter int WIDTHA     = asym_ram_arbiter_pkg::c_DEF_WIDTHA,
  parameter int ADDRWIDTHA = asym_ram_arbiter_pkg::c_DEF_ADDRWIDTHA,
  parameter int WIDTHB     = asym_ram_arbiter_pkg::c_DEF_WIDTHB,
  parameter int ADDRWIDTHB = asym_ram_arbiter_pkg::c_DEF_ADDRWIDTHB
);

  logic                  reqA;
  logic                  weA;
  logic [ADDRWIDTHA-1:0] addrA;
  logic [WIDTHA-1:0]     diA;
  logic                  gntA;
  logic                  rvalidA;
  logic [WIDTHA-1:0]     doA;

  logic                  reqB;
  logic                  weB;
  logic [ADDRWIDTHB-1:0] addrB;
  logic [WIDTHB-1:0]     diB;
  logic                  gntB;
  logic                  rvalidB;
  logic [WIDTHB-1:0]     doB;

  logic                  ram_we;
  logic [ADDRWIDTHA-1:0] ram_addr;
  logic [WIDTHA-1:0]     ram_di;
  logic [WIDTHA-1:0]     ram_do;
  logic                  busy;

  modport master (
    output reqA, weA, addrA, diA, reqB, weB, addrB, diB,
    input  gntA, rvalidA, doA, gntB, rvalidB, doB, busy
  );

  modport slave (
    input  reqA, weA, addrA, diA, reqB, weB, addrB, diB, ram_do,
    output gntA, rvalidA, doA, gntB, rvalidB, doB,
    output ram_we, ram_addr, ram_di, busy
  );

  modport memory (
    input  ram_we, ram_addr, ram_di,
    output ram_do
  );

endinterface
`default_nettype wire

// File: rtl/asym_lane_merge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// asym_lane_merge: replaces or extracts one narrow lane of a RAM word.
// Revision: 1.0
// ----------------------------------------------------------------------------
module asym_lane_merge
  import asym_ram_arbiter_pkg::*;
#(
  parameter int WIDTHA = c_DEF_WIDTHA,
  parameter int WIDTHB = c_DEF_WIDTHB,
  parameter int LANE_W = lane_w(WIDTHA, WIDTHB)
) (
  input  wire logic [WIDTHA-1:0] i_word,
  input  wire logic [LANE_W-1:0] i_lane,
  input  wire logic [WIDTHB-1:0] i_nibble,
  output logic      [WIDTHA-1:0] o_word,
  output logic      [WIDTHB-1:0] o_nibble
);

  localparam int c_LANES = WIDTHA / WIDTHB;

  for (genvar k = 0; k < c_LANES; k++) begin : g_lane
    assign o_word[k*WIDTHB +: WIDTHB] =
      (i_lane == LANE_W'(k)) ? i_nibble : i_word[k*WIDTHB +: WIDTHB];
  end

  always_comb begin
    o_nibble = '0;
    for (int k = 0; k < c_LANES; k++) begin
      if (i_lane == LANE_W'(k)) begin
        o_nibble = i_word[k*WIDTHB +: WIDTHB];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/asym_ram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// asym_ram_arbiter: shares one single-port word RAM between a wide and a
// narrow requester; narrow writes are read-modify-write.
// Option macro: ASYM_ARB_FIXED_PRIO_EN (A always wins contention).
// Revision: 1.0
// ----------------------------------------------------------------------------
module asym_ram_arbiter
  import asym_ram_arbiter_pkg::*;
#(
  parameter int WIDTHA     = c_DEF_WIDTHA,
  parameter int ADDRWIDTHA = c_DEF_ADDRWIDTHA,
  parameter int WIDTHB     = c_DEF_WIDTHB,
  parameter int ADDRWIDTHB = c_DEF_ADDRWIDTHB
) (
  input wire                clk,
  input wire                rst,
  asym_ram_arbiter_if.slave bus
);

  localparam int c_LANE_W = lane_w(WIDTHA, WIDTHB);

  state_t                r_state;
  sel_t                  r_sel;
  logic                  r_we;
  logic [c_LANE_W-1:0]   r_lane;
  logic [WIDTHB-1:0]     r_nib;
  logic [WIDTHA-1:0]     r_wdata;
  logic [ADDRWIDTHA-1:0] r_ram_addr;
  logic                  r_ram_we;
  logic                  r_gntA;
  logic                  r_gntB;
  logic                  r_rvalidA;
  logic                  r_rvalidB;
  logic [WIDTHA-1:0]     r_doA;
  logic [WIDTHB-1:0]     r_doB;

  logic                  w_req_any;
  logic                  w_win_a;
  logic [WIDTHA-1:0]     w_merged;
  logic [WIDTHB-1:0]     w_nibble;

  assign w_req_any = bus.reqA || bus.reqB;

`ifdef ASYM_ARB_FIXED_PRIO_EN
  assign w_win_a = bus.reqA;
`else
  sel_t r_ptr;

  assign w_win_a = bus.reqA && (!bus.reqB || (r_ptr == SEL_A));

  // The pointer always moves to the side that did not win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= SEL_A;
    end else if ((r_state == ST_IDLE) && w_req_any) begin
      r_ptr <= w_win_a ? SEL_B : SEL_A;
    end
  end
`endif

  asym_lane_merge #(
    .WIDTHA (WIDTHA),
    .WIDTHB (WIDTHB),
    .LANE_W (c_LANE_W)
  ) u_merge (
    .i_word   (bus.ram_do),
    .i_lane   (r_lane),
    .i_nibble (r_nib),
    .o_word   (w_merged),
    .o_nibble (w_nibble)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_A;
      r_we       <= 1'b0;
      r_lane     <= '0;
      r_nib      <= '0;
      r_wdata    <= '0;
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
      r_gntA     <= 1'b0;
      r_gntB     <= 1'b0;
      r_rvalidA  <= 1'b0;
      r_rvalidB  <= 1'b0;
      r_doA      <= '0;
      r_doB      <= '0;
    end else begin
      r_gntA    <= 1'b0;
      r_gntB    <= 1'b0;
      r_rvalidA <= 1'b0;
      r_rvalidB <= 1'b0;
      r_ram_we  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_state <= ST_ACCESS;
            if (w_win_a) begin
              r_sel      <= SEL_A;
              r_we       <= bus.weA;
              r_ram_addr <= bus.addrA;
              r_wdata    <= bus.diA;
              r_ram_we   <= bus.weA;
              r_gntA     <= 1'b1;
            end else begin
              r_sel      <= SEL_B;
              r_we       <= bus.weB;
              r_ram_addr <= bus.addrB[ADDRWIDTHB-1:c_LANE_W];
              r_lane     <= bus.addrB[c_LANE_W-1:0];
              r_nib      <= bus.diB;
              r_gntB     <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (r_we && (r_sel == SEL_A)) begin
            r_state <= ST_IDLE;
          end else if (r_we) begin
            // Read data arrives next cycle; the merged word is written then.
            r_state  <= ST_MERGE;
            r_ram_we <= 1'b1;
          end else begin
            r_state <= ST_RESP;
          end
        end
        ST_MERGE: begin
          r_state <= ST_IDLE;
        end
        ST_RESP: begin
          if (r_sel == SEL_A) begin
            r_doA     <= bus.ram_do;
            r_rvalidA <= 1'b1;
          end else begin
            r_doB     <= w_nibble;
            r_rvalidB <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Masking with rst keeps a reset during MERGE from committing a write.
  assign bus.ram_we   = r_ram_we & ~rst;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_di   = (r_state == ST_MERGE) ? w_merged : r_wdata;
  assign bus.gntA     = r_gntA;
  assign bus.gntB     = r_gntB;
  assign bus.rvalidA  = r_rvalidA;
  assign bus.rvalidB  = r_rvalidB;
  assign bus.doA      = r_doA;
  assign bus.doB      = r_doB;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_asym_ram_arbiter.sv
`default_nettype none
// tb_asym_ram_arbiter: directed and randomized checks of asym_ram_arbiter
// against a word-array reference memory and a registered-read RAM model.
module tb_asym_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  asym_ram_arbiter_if bus ();
  asym_ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] ram_mem [256];
  logic        preload;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (preload) ram_mem[pre_addr] <= pre_data;
    else if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_di;
    bus.ram_do <= ram_mem[bus.ram_addr];
  end

  logic [15:0] ref_mem [256];
  logic [15:0] qa [$];
  logic [3:0]  qb [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr_exp = 0;
  int          n_wr_obs = 0;
  int          n_grants = 0;
  int          n_rv_obs = 0;
  logic        last_b;
  logic [3:0]  exp_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_nib(input logic [9:0] a);
    int sh;
    sh = 4 * int'(a[1:0]);
    return 4'(ref_mem[a[9:2]] >> sh);
  endfunction

  task automatic ref_put_nib(input logic [9:0] a, input logic [3:0] d);
    int sh;
    sh = 4 * int'(a[1:0]);
    ref_mem[a[9:2]] = (ref_mem[a[9:2]] & ~(16'hF << sh)) | (16'(d) << sh);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the arbiter idle; returns at a negedge, idle again.
  task automatic tx_a(input logic we, input logic [7:0] addr, input logic [15:0] data,
                      input logic [15:0] exp_rd);
    bus.reqA = 1'b1; bus.weA = we; bus.addrA = addr; bus.diA = data;
    @(negedge clk);
    check("a_gntA", 32'(bus.gntA), 1);
    check("a_ram_we", 32'(bus.ram_we), 32'(we));
    check("a_ram_addr", 32'(bus.ram_addr), 32'(addr));
    bus.reqA = 1'b0;
    if (we) begin
      check("a_ram_di", 32'(bus.ram_di), 32'(data));
      ref_mem[addr] = data;
      @(negedge clk);
      check("a_wr_idle", 32'({bus.busy, bus.ram_we}), 0);
    end else begin
      @(negedge clk);
      check("a_rv_early", 32'(bus.rvalidA), 0);
      @(negedge clk);
      check("a_rvalid_doA", 32'({bus.rvalidA, bus.doA}), 32'({1'b1, exp_rd}));
    end
  endtask

  // exp_val is the merged word for writes, the expected nibble for reads.
  task automatic tx_b(input logic we, input logic [9:0] addr, input logic [3:0] data,
                      input logic [15:0] exp_val);
    bus.reqB = 1'b1; bus.weB = we; bus.addrB = addr; bus.diB = data;
    @(negedge clk);
    check("b_gntB", 32'(bus.gntB), 1);
    check("b_ram_we_c1", 32'(bus.ram_we), 0);
    check("b_ram_addr", 32'(bus.ram_addr), 32'(addr[9:2]));
    bus.reqB = 1'b0;
    @(negedge clk);
    if (we) begin
      check("b_merge_we", 32'(bus.ram_we), 1);
      check("b_merge_di", 32'(bus.ram_di), 32'(exp_val));
      ref_mem[addr[9:2]] = exp_val;
      @(negedge clk);
      check("b_wr_idle", 32'({bus.busy, bus.ram_we}), 0);
    end else begin
      check("b_rv_early", 32'(bus.rvalidB), 0);
      @(negedge clk);
      check("b_rvalid_doB", 32'({bus.rvalidB, bus.doB}), 32'({1'b1, exp_val[3:0]}));
    end
  endtask

  // Observes one cycle of the random run: grants update the reference model.
  task automatic monitor_cycle();
    logic exp_a;
    if (bus.ram_we) n_wr_obs++;
    if (bus.gntA || bus.gntB) begin
      n_grants++;
`ifdef ASYM_ARB_FIXED_PRIO_EN
      exp_a = bus.reqA;
`else
      exp_a = bus.reqA && (!bus.reqB || last_b);
`endif
      check("rnd_gntA", 32'(bus.gntA), 32'(exp_a));
      check("rnd_gntB", 32'(bus.gntB), 32'(!exp_a));
      last_b = bus.gntB;
    end
    if (bus.gntA) begin
      if (bus.weA) begin ref_mem[bus.addrA] = bus.diA; n_wr_exp++; end
      else qa.push_back(ref_mem[bus.addrA]);
      bus.reqA = 1'b0;
    end
    if (bus.gntB) begin
      if (bus.weB) begin ref_put_nib(bus.addrB, bus.diB); n_wr_exp++; end
      else qb.push_back(ref_nib(bus.addrB));
      bus.reqB = 1'b0;
    end
    if (bus.rvalidA) begin
      n_rv_obs++;
      check("rnd_rvA_pending", 32'(qa.size()), 1);
      if (qa.size() > 0) check("rnd_doA", 32'(bus.doA), 32'(qa.pop_front()));
    end
    if (bus.rvalidB) begin
      n_rv_obs++;
      check("rnd_rvB_pending", 32'(qb.size()), 1);
      if (qb.size() > 0) check("rnd_doB", 32'(bus.doB), 32'(qb.pop_front()));
    end
  endtask

  task automatic stim();
    if (!bus.reqA) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.reqA  = 1'b1;
        bus.weA   = 1'($urandom_range(0, 1));
        bus.addrA = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        bus.diA   = 16'($urandom);
      end
    end else if ($urandom_range(0, 63) == 0) begin
      bus.reqA = 1'b0;
    end
    if (!bus.reqB) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.reqB  = 1'b1;
        bus.weB   = 1'($urandom_range(0, 1));
        bus.addrB = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 63)) : 10'($urandom);
        bus.diB   = 4'($urandom);
      end
    end else if ($urandom_range(0, 63) == 0) begin
      bus.reqB = 1'b0;
    end
  endtask

  initial begin
`ifdef ASYM_ARB_FIXED_PRIO_EN
    exp_rr = 4'b1111;
`else
    exp_rr = 4'b0101;
`endif
    rst = 1'b1; preload = 1'b1; pre_addr = '0; pre_data = '0;
    bus.reqA = 1'b0; bus.weA = 1'b0; bus.addrA = '0; bus.diA = '0;
    bus.reqB = 1'b0; bus.weB = 1'b0; bus.addrB = '0; bus.diB = '0;
    for (int i = 0; i < 256; i++) begin
      pre_addr = 8'(i);
      pre_data = 16'($urandom);
      ref_mem[i] = pre_data;
      @(negedge clk);
    end
    preload = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_grants_rvalid", 32'({bus.gntA, bus.gntB, bus.rvalidA, bus.rvalidB}), 0);
    check("rst_doA_doB", 32'({bus.doA, bus.doB}), 0);
    check("rst_ram_if", 32'({bus.ram_we, bus.ram_addr, bus.ram_di}), 0);
    check("rst_busy", 32'(bus.busy), 0);

    tx_a(1'b1, 8'h12, 16'hBEEF, 16'h0);
    tx_b(1'b0, 10'h048, 4'h0, 16'hF);
    tx_b(1'b0, 10'h049, 4'h0, 16'hE);
    tx_b(1'b0, 10'h04A, 4'h0, 16'hE);
    tx_b(1'b0, 10'h04B, 4'h0, 16'hB);

    tx_a(1'b1, 8'h40, 16'h1234, 16'h0);
    tx_b(1'b1, 10'h102, 4'hA, 16'h1A34);
    tx_a(1'b0, 8'h40, 16'h0, 16'h1A34);

    // Reset landing on the MERGE cycle must suppress the write.
    bus.reqB = 1'b1; bus.weB = 1'b1; bus.addrB = 10'h005; bus.diB = ~ref_nib(10'h005);
    @(negedge clk);
    check("rm_gntB", 32'(bus.gntB), 1);
    bus.reqB = 1'b0;
    @(negedge clk);
    check("rm_in_merge", 32'(bus.ram_we), 1);
    rst = 1'b1;
    #1;
    check("rm_we_blocked", 32'(bus.ram_we), 0);
    @(negedge clk);
    check("rm_after_rst", 32'({bus.gntB, bus.busy, bus.ram_we, bus.rvalidB}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rm_stays_idle", 32'({bus.gntB, bus.busy, bus.ram_we, bus.rvalidB}), 0);
    tx_a(1'b0, 8'h01, 16'h0, ref_mem[1]);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 8'h12;
      bus.reqB = 1'b1; bus.weB = 1'b0; bus.addrB = 10'h102;
      @(negedge clk);
      check("rr_gntA", 32'(bus.gntA), 32'(exp_rr[i]));
      check("rr_gntB", 32'(bus.gntB), 32'(!exp_rr[i]));
      bus.reqA = 1'b0; bus.reqB = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (exp_rr[i]) check("rr_doA", 32'({bus.rvalidA, bus.doA}), 32'h1BEEF);
      else           check("rr_doB", 32'({bus.rvalidB, bus.doB}), 32'h1A);
    end

    do_reset();
    last_b = 1'b1;
    for (int c = 0; c < 2048; c++) begin
      @(negedge clk);
      monitor_cycle();
      stim();
    end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      monitor_cycle();
    end
    check("drain_served", 32'({bus.reqA, bus.reqB, bus.busy}), 0);
    check("drain_qa_empty", 32'(qa.size()), 0);
    check("drain_qb_empty", 32'(qb.size()), 0);
    check("write_count", 32'(n_wr_obs), 32'(n_wr_exp));
    check("grant_accounting", 32'(n_grants), 32'(n_wr_obs + n_rv_obs));
    for (int i = 0; i < 256; i++) begin
      check("final_mem", {8'(i), 8'h00, ram_mem[i]}, {8'(i), 8'h00, ref_mem[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/asym_ram_arbiter.md
Name: asym_ram_arbiter

Overview:
- Single-clock arbiter sharing one single-port 16-bit x 256 RAM between a wide requester (16-bit words, 8-bit address) and a narrow requester (4-bit nibbles, 10-bit address).
- Narrow writes are done as read-modify-write. Narrow reads extract one nibble from the stored word.
- Sits between two bus masters and the RAM macro. Presents each master the same word/nibble view as the asymmetric dual-port RAM.

Parameters:
- WIDTHA, 16, wide data width; also the RAM word width.
- ADDRWIDTHA, 8, wide address width; also the RAM address width.
- WIDTHB, 4, narrow data width. WIDTHA/WIDTHB must be a power of two.
- ADDRWIDTHB, 10, narrow address width; equals ADDRWIDTHA + log2(WIDTHA/WIDTHB).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- reqA  in  1  wide request; held with weA/addrA/diA until gntA
- weA  in  1  wide write enable (1 = write, 0 = read)
- addrA  in  ADDRWIDTHA  wide word address
- diA  in  WIDTHA  wide write data
- gntA  out  1  one-cycle grant pulse
- rvalidA  out  1  one-cycle read-data-valid pulse
- doA  out  WIDTHA  wide read data; held until next wide read
- reqB, weB, addrB, diB, gntB, rvalidB, doB: same roles on the narrow side, with widths 1, 1, ADDRWIDTHB, WIDTHB, 1, 1, WIDTHB
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDRWIDTHA  RAM address
- ram_di  out  WIDTHA  RAM write data
- ram_do  in  WIDTHA  RAM read data; valid one cycle after address is issued (registered read)
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: every output 0; FSM = IDLE; round-robin pointer = A. Reset mid-transaction returns to IDLE and drops the transaction: no grant, no rvalid, no write. A narrow write is never torn, because the only RAM write happens in a single cycle.
- Lane mapping: ram_addr = addrB[ADDRWIDTHB-1:2]. Lane = addrB[1:0]; lane 0 = bits [3:0], lane 3 = bits [15:12].
- Arbitration is evaluated only in IDLE:
  - One request only: that requester wins.
  - Both requests: the pointer side wins.
  - Pointer is then set to the loser.
  - The winner's command is latched and gnt<winner> is registered high in the next cycle (1 cycle).
- FSM states: IDLE, ACCESS, MERGE, RESP.
  - IDLE -> ACCESS on any request.
  - ACCESS, wide write: ram_we=1, ram_addr=addrA, ram_di=diA -> IDLE.
  - ACCESS, any read or narrow write: ram_we=0, ram_addr driven from latched address. Read -> RESP; narrow write -> MERGE.
  - MERGE: ram_we=1; ram_di = ram_do with the selected lane replaced by diB -> IDLE.
  - RESP: doA <= ram_do, or doB <= selected lane of ram_do; rvalid<winner> <= 1 -> IDLE.
- gnt is high during the ACCESS cycle.
- Latency from request sampled (cycle 0):
  - Wide write: RAM written end of cycle 1.
  - Narrow write: RAM written end of cycle 2.
  - Reads: rvalid high in cycle 3.
- Next request can be sampled in the cycle the FSM re-enters IDLE.
- A request deasserted before grant is withdrawn without error.
- Back-to-back writes to the same word from both sides serialize in grant order; the last writer's data prevails. A narrow RMW therefore always sees prior wide writes.
- Unused address/data bits are ignored; no bounds check is needed, since widths cover the RAM exactly.

Optional Feature:
- Macro ASYM_ARB_FIXED_PRIO_EN.
- Defined: A always wins a simultaneous request; the pointer is not implemented. B can starve.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package asym_ram_arbiter_pkg holds:
  - FSM state enum (IDLE/ACCESS/MERGE/RESP).
  - Requester-select enum (SEL_A/SEL_B).
  - Lane-count constant and lane-select width.
  - Default width constants.
- One sub-module, asym_lane_merge (combinational):
  - Inputs: word, lane index, nibble.
  - Outputs: merged word and extracted nibble.
  - Used by both MERGE and RESP.

Test Plan:
- Reset then idle: all outputs 0 and busy=0. Assert rst during MERGE of a narrow write to addrB=0x005 -> no ram_we, gntB stays 0 afterwards, state IDLE.
- Wide write then narrow read:
  - Wide write: addrA=0x12, diA=0xBEEF -> ram_we at cycle 1 with ram_addr=0x12.
  - Narrow reads addrB=0x048..0x04B -> doB=F, E, E, B in order, each with rvalidB at cycle 3.
- Narrow RMW: RAM word 0x40 = 0x1234; narrow write addrB=0x102, diB=0xA -> MERGE writes ram_di=0x1A34. A subsequent wide read of addrA=0x40 -> doA=0x1A34.
- Simultaneous requests after reset, repeated 4 times -> grants A,B,A,B (round-robin). Same test with ASYM_ARB_FIXED_PRIO_EN -> A,A,A,A.
- Random co-simulation against a behavioural 16x256 memory model: 2048 cycles of random reqA/reqB/we/addr/data -> zero doA/doB mismatches, and every granted request produces exactly one write or one rvalid.
